// File: rtl/ppu_arbiter.sv
// Two-requester round-robin front end for a single PPU. One operation in
// flight at a time: accept in IDLE, issue for one cycle, wait for the result
// (bounded by TIMEOUT), then pulse done to the winner and return to IDLE.
// Per-requester result/err registers hold until that requester completes again.
module ppu_arbiter #(
  parameter int OP_W    = 3,
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0_valid_i,
  input  logic [OP_W-1:0] req0_op_i,
  input  logic [31:0]     req0_a_i,
  input  logic [31:0]     req0_b_i,
  input  logic            req1_valid_i,
  input  logic [OP_W-1:0] req1_op_i,
  input  logic [31:0]     req1_a_i,
  input  logic [31:0]     req1_b_i,
  output logic            req0_ready_o,
  output logic            req0_done_o,
  output logic            req0_err_o,
  output logic [31:0]     req0_result_o,
  output logic            req1_ready_o,
  output logic            req1_done_o,
  output logic            req1_err_o,
  output logic [31:0]     req1_result_o,
  output logic            ppu_valid_in_o,
  output logic [31:0]     ppu_in1_o,
  output logic [31:0]     ppu_in2_o,
  output logic [OP_W-1:0] ppu_op_o,
  input  logic [31:0]     ppu_out_i,
  input  logic            ppu_valid_o_i,
  output logic            busy_o,
  output logic [7:0]      stray_cnt_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Wait count at which an unanswered operation gives up (counter runs from the ISSUE cycle).
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic              grant_q, grant_d;
  logic              last_grant_q, last_grant_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [31:0]       a_q, a_d;
  logic [31:0]       b_q, b_d;
  logic [31:0]       res0_q, res0_d;
  logic [31:0]       res1_q, res1_d;
  logic              err0_q, err0_d;
  logic              err1_q, err1_d;
  logic [7:0]        stray_q, stray_d;

  logic              any_req_s;
  logic              pick_s;
  logic              fin_s;
  logic              fin_err_s;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Round-robin choice: on a tie the requester that did not win last time goes.
  always_comb begin
    any_req_s = req0_valid_i | req1_valid_i;
    if (req0_valid_i && req1_valid_i) begin
      pick_s = ~last_grant_q;
    end else if (req1_valid_i) begin
      pick_s = 1'b1;
    end else begin
      pick_s = 1'b0;
    end
  end

  // Next-state, operand latching, completion and stray-valid accounting.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    res0_d       = res0_q;
    res1_d       = res1_q;
    err0_d       = err0_q;
    err1_d       = err1_q;
    stray_d      = stray_q;
    fin_s        = 1'b0;
    fin_err_s    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (ppu_valid_o_i) begin
          stray_d = sat_inc(stray_q);
        end else begin
          stray_d = stray_q;
        end
        if (any_req_s) begin
          grant_d = pick_s;
          op_d    = pick_s ? req1_op_i : req0_op_i;
          a_d     = pick_s ? req1_a_i  : req0_a_i;
          b_d     = pick_s ? req1_b_i  : req0_b_i;
          cnt_d   = 8'd0;
          state_d = S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        cnt_d = cnt_q + 8'd1;
        if (ppu_valid_o_i) begin
          fin_s   = 1'b1;
          state_d = S_DONE;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (ppu_valid_o_i) begin
          fin_s   = 1'b1;
          state_d = S_DONE;
        end else if (cnt_q == TO_LAST) begin
          fin_s     = 1'b1;
          fin_err_s = 1'b1;
          state_d   = S_DONE;
        end else begin
          cnt_d   = cnt_q + 8'd1;
          state_d = S_WAIT;
        end
      end
      S_DONE: begin
        if (ppu_valid_o_i) begin
          stray_d = sat_inc(stray_q);
        end else begin
          stray_d = stray_q;
        end
        last_grant_d = grant_q;
        state_d      = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Completion lands only in the granted requester's result/err registers.
    if (fin_s) begin
      if (grant_q) begin
        res1_d = fin_err_s ? 32'd0 : ppu_out_i;
        err1_d = fin_err_s;
      end else begin
        res0_d = fin_err_s ? 32'd0 : ppu_out_i;
        err0_d = fin_err_s;
      end
    end else begin
      fin_err_s = 1'b0;
    end
  end

  // State register with synchronous reset; last_grant resets to 1 so req0 wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      cnt_q        <= 8'd0;
      op_q         <= {OP_W{1'b0}};
      a_q          <= 32'd0;
      b_q          <= 32'd0;
      res0_q       <= 32'd0;
      res1_q       <= 32'd0;
      err0_q       <= 1'b0;
      err1_q       <= 1'b0;
      stray_q      <= 8'd0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      res0_q       <= res0_d;
      res1_q       <= res1_d;
      err0_q       <= err0_d;
      err1_q       <= err1_d;
      stray_q      <= stray_d;
    end
  end

  // Output decode; ready is combinational on the request and forced low under reset.
  always_comb begin
    req0_ready_o   = (state_q == S_IDLE) && !rst && any_req_s && !pick_s;
    req1_ready_o   = (state_q == S_IDLE) && !rst && any_req_s &&  pick_s;
    req0_done_o    = (state_q == S_DONE) && !grant_q;
    req1_done_o    = (state_q == S_DONE) &&  grant_q;
    req0_err_o     = err0_q;
    req1_err_o     = err1_q;
    req0_result_o  = res0_q;
    req1_result_o  = res1_q;
    ppu_valid_in_o = (state_q == S_ISSUE);
    busy_o         = (state_q != S_IDLE);
    stray_cnt_o    = stray_q;
    if ((state_q == S_ISSUE) || (state_q == S_WAIT)) begin
      ppu_in1_o = a_q;
      ppu_in2_o = b_q;
      ppu_op_o  = op_q;
    end else begin
      ppu_in1_o = 32'd0;
      ppu_in2_o = 32'd0;
      ppu_op_o  = {OP_W{1'b0}};
    end
  end

endmodule
